// File: rtl/ifetch_pc.sv
// Fetch-PC generator for the 5-stage pipeline; keeps the ID-stage PC/valid aligned with
// the instruction memory's registered output. Optional feature: IFETCH_MISALIGN_TRAP_EN.
module ifetch_pc #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic        i_stall,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic [31:0] o_imem_addr,
    output logic        o_imem_stall,
    output logic        o_imem_flush,
    output logic [31:0] o_pc_id,
    output logic [31:0] o_pc4_id,
    output logic        o_valid_id,
    output logic        o_misalign,
    output logic [31:0] o_trap_addr
);

    typedef enum logic [0:0] {StRun, StHalt} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pc_id_q, pc_id_d;
    logic        valid_q, valid_d;
    logic        halt;

    assign halt = (state_q == StHalt);

    // Redirect overrides stall so a taken branch is never lost behind a hazard.
    assign o_imem_stall = i_stall & ~i_redirect & ~halt;
    assign o_imem_flush = i_redirect | halt;
    assign o_imem_addr  = pc_q;
    assign o_pc_id      = pc_id_q;
    assign o_pc4_id     = pc_id_q + 32'd4;
    assign o_valid_id   = valid_q;

`ifdef IFETCH_MISALIGN_TRAP_EN
    logic        misalign_q, misalign_d;
    logic [31:0] trap_addr_q, trap_addr_d;

    assign o_misalign  = misalign_q;
    assign o_trap_addr = trap_addr_q;
`else
    logic unused_redirect_lsb;

    assign unused_redirect_lsb = ^i_redirect_pc[1:0];
    assign o_misalign          = 1'b0;
    assign o_trap_addr         = 32'h0;
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        pc_id_d = pc_id_q;
        valid_d = valid_q;
`ifdef IFETCH_MISALIGN_TRAP_EN
        misalign_d  = 1'b0;
        trap_addr_d = trap_addr_q;
`endif
        if (i_redirect) begin
            valid_d = 1'b0;
`ifdef IFETCH_MISALIGN_TRAP_EN
            if (i_redirect_pc[1:0] != 2'b00) begin
                // Freeze fetch at the current PC until software redirects to an aligned target.
                state_d     = StHalt;
                misalign_d  = 1'b1;
                trap_addr_d = i_redirect_pc;
            end else begin
                state_d = StRun;
                pc_d    = i_redirect_pc;
            end
`else
            pc_d = {i_redirect_pc[31:2], 2'b00};
`endif
        end else if (halt) begin
            valid_d = 1'b0;
        end else if (!i_stall) begin
            pc_id_d = pc_q;
            pc_d    = pc_q + 32'd4;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= StRun;
            pc_q    <= RESET_PC;
            pc_id_q <= 32'h0;
            valid_q <= 1'b0;
`ifdef IFETCH_MISALIGN_TRAP_EN
            misalign_q  <= 1'b0;
            trap_addr_q <= 32'h0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            pc_id_q <= pc_id_d;
            valid_q <= valid_d;
`ifdef IFETCH_MISALIGN_TRAP_EN
            misalign_q  <= misalign_d;
            trap_addr_q <= trap_addr_d;
`endif
        end
    end

endmodule

// File: tb/tb_ifetch_pc.sv
// Directed-vector bench for ifetch_pc: reset, sequential fetch, stall, redirect,
// back-to-back redirect, address wrap, misaligned redirect and mid-stream reset.
module tb_ifetch_pc;

    logic        clk;
    logic        rstn;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic        imem_stall;
    logic        imem_flush;
    logic [31:0] pc_id;
    logic [31:0] pc4_id;
    logic        valid_id;
    logic        misalign;
    logic [31:0] trap_addr;

    int checks;
    int passed;

    ifetch_pc #(.RESET_PC(32'h0000_0000)) dut (
        .i_clk         (clk),
        .i_rstn        (rstn),
        .i_stall       (stall),
        .i_redirect    (redirect),
        .i_redirect_pc (redirect_pc),
        .o_imem_addr   (imem_addr),
        .o_imem_stall  (imem_stall),
        .o_imem_flush  (imem_flush),
        .o_pc_id       (pc_id),
        .o_pc4_id      (pc4_id),
        .o_valid_id    (valid_id),
        .o_misalign    (misalign),
        .o_trap_addr   (trap_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rstn = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        #1;
        checks++; if (imem_addr !== 32'h0) $display("FAIL rst_addr got %h want %h", imem_addr, 32'h0); else passed++;
        checks++; if (valid_id !== 1'b0) $display("FAIL rst_valid got %b want 0", valid_id); else passed++;
        checks++; if (pc_id !== 32'h0) $display("FAIL rst_pc_id got %h want 0", pc_id); else passed++;
        checks++; if (misalign !== 1'b0 || trap_addr !== 32'h0)
            $display("FAIL rst_trap got %b/%h want 0/0", misalign, trap_addr); else passed++;
        tick(); tick();
        rstn = 1'b1;
        #1;
        checks++; if (imem_flush !== 1'b0 || imem_stall !== 1'b0)
            $display("FAIL rst_ctrl got flush %b stall %b want 0 0", imem_flush, imem_stall); else passed++;
    endtask

    task automatic test_fetch();
        logic [31:0] exp_addr [4] = '{32'h4, 32'h8, 32'hC, 32'h10};
        logic [31:0] exp_id   [4] = '{32'h0, 32'h4, 32'h8, 32'hC};
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (imem_addr !== exp_addr[i])
                $display("FAIL fetch_addr[%0d] got %h want %h", i, imem_addr, exp_addr[i]); else passed++;
            checks++; if (pc_id !== exp_id[i] || valid_id !== 1'b1)
                $display("FAIL fetch_id[%0d] got %h/%b want %h/1", i, pc_id, valid_id, exp_id[i]); else passed++;
            checks++; if (pc4_id !== exp_id[i] + 32'd4)
                $display("FAIL fetch_pc4[%0d] got %h want %h", i, pc4_id, exp_id[i] + 32'd4); else passed++;
        end
    endtask

    task automatic test_stall();
        stall = 1'b1;
        #1;
        checks++; if (imem_stall !== 1'b1 || imem_flush !== 1'b0)
            $display("FAIL stall_ctrl got stall %b flush %b want 1 0", imem_stall, imem_flush); else passed++;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (imem_addr !== 32'h10 || pc_id !== 32'hC || valid_id !== 1'b1)
                $display("FAIL stall_hold[%0d] got %h/%h/%b want 10/c/1", i, imem_addr, pc_id, valid_id);
            else passed++;
        end
        stall = 1'b0;
        tick();
        checks++; if (imem_addr !== 32'h14 || pc_id !== 32'h10)
            $display("FAIL stall_resume got %h/%h want 14/10", imem_addr, pc_id); else passed++;
    endtask

    task automatic test_redirect();
        stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h100;
        #1;
        checks++; if (imem_flush !== 1'b1 || imem_stall !== 1'b0)
            $display("FAIL redir_ctrl got flush %b stall %b want 1 0", imem_flush, imem_stall); else passed++;
        tick();
        stall = 1'b0; redirect = 1'b0;
        checks++; if (valid_id !== 1'b0 || imem_addr !== 32'h100 || pc_id !== 32'h10)
            $display("FAIL redir_bubble got %b/%h/%h want 0/100/10", valid_id, imem_addr, pc_id); else passed++;
        tick();
        checks++; if (pc_id !== 32'h100 || valid_id !== 1'b1 || imem_addr !== 32'h104)
            $display("FAIL redir_target got %h/%b/%h want 100/1/104", pc_id, valid_id, imem_addr); else passed++;
    endtask

    task automatic test_back_to_back();
        redirect = 1'b1; redirect_pc = 32'h200;
        tick();
        redirect_pc = 32'h300;
        tick();
        redirect = 1'b0;
        checks++; if (valid_id !== 1'b0 || imem_addr !== 32'h300)
            $display("FAIL b2b_last got %b/%h want 0/300", valid_id, imem_addr); else passed++;
        tick();
        checks++; if (pc_id !== 32'h300 || valid_id !== 1'b1)
            $display("FAIL b2b_target got %h/%b want 300/1", pc_id, valid_id); else passed++;
    endtask

    task automatic test_wrap();
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect = 1'b0;
        checks++; if (imem_addr !== 32'hFFFF_FFFC)
            $display("FAIL wrap_load got %h want fffffffc", imem_addr); else passed++;
        tick();
        checks++; if (imem_addr !== 32'h0 || pc_id !== 32'hFFFF_FFFC || pc4_id !== 32'h0)
            $display("FAIL wrap got %h/%h/%h want 0/fffffffc/0", imem_addr, pc_id, pc4_id); else passed++;
        tick();
        checks++; if (imem_addr !== 32'h4 || pc_id !== 32'h0)
            $display("FAIL wrap_next got %h/%h want 4/0", imem_addr, pc_id); else passed++;
    endtask

    task automatic test_misalign();
        redirect = 1'b1; redirect_pc = 32'h102;
        tick();
        redirect = 1'b0;
`ifdef IFETCH_MISALIGN_TRAP_EN
        checks++; if (misalign !== 1'b1 || trap_addr !== 32'h102 || valid_id !== 1'b0 || imem_addr !== 32'h4)
            $display("FAIL mis_trap got %b/%h/%b/%h want 1/102/0/4", misalign, trap_addr, valid_id, imem_addr);
        else passed++;
        stall = 1'b1;
        #1;
        checks++; if (imem_stall !== 1'b0 || imem_flush !== 1'b1)
            $display("FAIL mis_halt_ctrl got stall %b flush %b want 0 1", imem_stall, imem_flush); else passed++;
        tick();
        stall = 1'b0;
        checks++; if (misalign !== 1'b0 || trap_addr !== 32'h102 || valid_id !== 1'b0 || imem_addr !== 32'h4)
            $display("FAIL mis_hold got %b/%h/%b/%h want 0/102/0/4", misalign, trap_addr, valid_id, imem_addr);
        else passed++;
        tick();
        checks++; if (imem_addr !== 32'h4 || valid_id !== 1'b0)
            $display("FAIL mis_frozen got %h/%b want 4/0", imem_addr, valid_id); else passed++;
        redirect = 1'b1; redirect_pc = 32'h200;
        tick();
        redirect = 1'b0;
        checks++; if (imem_addr !== 32'h200 || valid_id !== 1'b0)
            $display("FAIL mis_exit got %h/%b want 200/0", imem_addr, valid_id); else passed++;
        tick();
        checks++; if (pc_id !== 32'h200 || valid_id !== 1'b1)
            $display("FAIL mis_resume got %h/%b want 200/1", pc_id, valid_id); else passed++;
`else
        checks++; if (imem_addr !== 32'h100 || valid_id !== 1'b0 || misalign !== 1'b0 || trap_addr !== 32'h0)
            $display("FAIL mis_forced got %h/%b/%b/%h want 100/0/0/0", imem_addr, valid_id, misalign, trap_addr);
        else passed++;
        tick();
        checks++; if (pc_id !== 32'h100 || valid_id !== 1'b1 || imem_addr !== 32'h104)
            $display("FAIL mis_fetch got %h/%b/%h want 100/1/104", pc_id, valid_id, imem_addr); else passed++;
`endif
    endtask

    task automatic test_reset_mid();
        redirect = 1'b1; redirect_pc = 32'h38;
        tick();
        redirect = 1'b0;
        tick();
        tick();
        checks++; if (imem_addr !== 32'h40 || pc_id !== 32'h3C || valid_id !== 1'b1)
            $display("FAIL mid_pre got %h/%h/%b want 40/3c/1", imem_addr, pc_id, valid_id); else passed++;
        rstn = 1'b0;
        #1;
        checks++; if (imem_addr !== 32'h0 || valid_id !== 1'b0 || pc_id !== 32'h0)
            $display("FAIL mid_rst got %h/%b/%h want 0/0/0", imem_addr, valid_id, pc_id); else passed++;
        tick();
        rstn = 1'b1;
        tick();
        checks++; if (imem_addr !== 32'h4 || pc_id !== 32'h0 || valid_id !== 1'b1)
            $display("FAIL mid_restart got %h/%h/%b want 4/0/1", imem_addr, pc_id, valid_id); else passed++;
    endtask

    initial begin
        checks = 0;
        passed = 0;
        test_reset();
        test_fetch();
        test_stall();
        test_redirect();
        test_back_to_back();
        test_wrap();
        test_misalign();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
